sa_edge_feeder: RTL and testbench

- Drives one input edge (A side or B side) of an N-lane systolic array of accumulate-and-forward PEs.
- Accepts a stream of LEN N-element vectors over a valid/ready handshake.
- Skews lane i by i cycles and zero-pads the tail.
- Generates the array-wide EN so the whole array stalls with the stream and then drains until the last PE has accumulated.

---
 rtl/sa_edge_feeder.sv | 125 ++++++++++++
 tb/tb_sa_edge_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_edge_feeder.sv
// =============================================================================
// sa_edge_feeder : skewed, zero-padded edge feeder and EN generator for an
//                  N-lane systolic array                         | rev 1.0
// =============================================================================
`default_nettype none

module sa_edge_feeder #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int LW = 16
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           START,
  input  logic [LW-1:0]  LEN,
  output logic           BUSY,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [N*W-1:0] IN_DATA,
  output logic [N*W-1:0] LANE_OUT,
  output logic           EN_OUT,
  output logic           DONE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_LAST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int             c_FCW        = $clog2(2 * N);
  localparam logic [c_FCW-1:0] c_FLUSH_INIT = c_FCW'(2 * N - 1);

  state_t             state_q, state_d;
  logic [LW-1:0]      rem_q, rem_d;
  logic [c_FCW-1:0]   fcnt_q, fcnt_d;
  logic               en_q;
  logic               w_adv;
  logic [N*W-1:0]     w_head;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fcnt_d  = fcnt_q;
    w_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (LEN == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = LEN;
            state_d = S_FEED;
          end
        end
      end
      S_FEED: begin
        w_adv = IN_VALID;
        if (IN_VALID) begin
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            fcnt_d  = c_FLUSH_INIT;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // 2N-1 zero steps: skew (N-1) + far-column traversal (N-1) + accumulate
        w_adv  = 1'b1;
        fcnt_d = fcnt_q - c_FCW'(1);
        if (fcnt_q == c_FCW'(1)) begin
          state_d = S_LAST;
        end
      end
      S_LAST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      fcnt_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
      en_q    <= w_adv;
    end
  end

  assign w_head = (state_q == S_FEED) ? IN_DATA : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [W-1:0] sr_q [0:gi];

    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        for (int s = 0; s <= gi; s++) begin
          sr_q[s] <= '0;
        end
      end else if (w_adv) begin
        sr_q[0] <= w_head[gi*W +: W];
        for (int s = 1; s <= gi; s++) begin
          sr_q[s] <= sr_q[s-1];
        end
      end
    end

    assign LANE_OUT[gi*W +: W] = sr_q[gi];
  end

  assign BUSY     = (state_q != S_IDLE);
  assign IN_READY = (state_q == S_FEED);
  assign DONE     = (state_q == S_DONE);
  assign EN_OUT   = en_q;

endmodule

`default_nettype wire

// File: tb/tb_sa_edge_feeder.sv
// =============================================================================
// tb_sa_edge_feeder : directed and randomized bench for sa_edge_feeder | rev 1.0
// =============================================================================
`default_nettype none

module tb_sa_edge_feeder;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 16;
  localparam int NW = N * W;
  localparam int K2 = 3;

  logic          CLK = 1'b0;
  logic          RSTN, START, IN_VALID;
  logic [LW-1:0] LEN;
  logic [NW-1:0] IN_DATA, IN_DATA_B;
  logic          BUSY, IN_READY, EN_OUT, DONE;
  logic [NW-1:0] LANE_OUT;
  logic          BUSY_B, IN_READY_B, EN_OUT_B, DONE_B;
  logic [NW-1:0] LANE_OUT_B;

  always #5 CLK = ~CLK;

  sa_edge_feeder #(.N(N), .W(W), .LW(LW)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN), .BUSY(BUSY),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .LANE_OUT(LANE_OUT), .EN_OUT(EN_OUT), .DONE(DONE)
  );

  sa_edge_feeder #(.N(N), .W(W), .LW(LW)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN), .BUSY(BUSY_B),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY_B), .IN_DATA(IN_DATA_B),
    .LANE_OUT(LANE_OUT_B), .EN_OUT(EN_OUT_B), .DONE(DONE_B)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chkv(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chki(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: run = LEN data steps + 2N-1 zero steps
  int            mphase;   // 0 idle, 1 running, 2 last, 3 done
  int            mlen, macc, msteps;
  logic [NW-1:0] hist[$];
  logic          m_en;
  logic          e_busy, e_ready, e_en, e_done;
  logic [NW-1:0] e_lanes;
  bit            mvalid = 1'b0;

  longint acc[N][N];
  longint a_r[N][N];
  longint b_r[N][N];

  task automatic pe_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        acc[r][c] = 0; a_r[r][c] = 0; b_r[r][c] = 0;
      end
  endtask

  function automatic logic [NW-1:0] model_lanes();
    logic [NW-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < N; i++) begin
      idx = msteps - 1 - i;
      if (idx >= 0 && idx < hist.size()) v[i*W +: W] = hist[idx][i*W +: W];
    end
    return v;
  endfunction

  initial begin
    longint na[N][N];
    longint nb[N][N];
    longint ain, bin;
    logic   adv;
    forever begin
      @(negedge CLK);
      if (mvalid) begin
        chk1("cyc_busy",  BUSY,     e_busy);
        chk1("cyc_ready", IN_READY, e_ready);
        chk1("cyc_en",    EN_OUT,   e_en);
        chk1("cyc_done",  DONE,     e_done);
        chkv("cyc_lanes", LANE_OUT, e_lanes);
      end
      if (EN_OUT === 1'b1) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ain = (c == 0) ? longint'(LANE_OUT[r*W +: W])   : a_r[r][c-1];
            bin = (r == 0) ? longint'(LANE_OUT_B[c*W +: W]) : b_r[r-1][c];
            acc[r][c] += ain * bin;
            na[r][c] = ain;
            nb[r][c] = bin;
          end
        a_r = na;
        b_r = nb;
      end
      if (!RSTN) begin
        mphase = 0; mlen = 0; macc = 0; msteps = 0; m_en = 1'b0;
        hist.delete();
        mvalid = 1'b1;
      end else begin
        case (mphase)
          0: begin
            m_en = 1'b0;
            if (START) begin
              if (LEN == '0) mphase = 3;
              else begin
                mphase = 1; mlen = int'(LEN); macc = 0; msteps = 0;
                hist.delete();
              end
            end
          end
          1: begin
            adv = (macc < mlen) ? IN_VALID : 1'b1;
            if (adv) begin
              if (macc < mlen) begin
                hist.push_back(IN_DATA);
                macc++;
              end
              msteps++;
            end
            m_en = adv;
            if (msteps == mlen + 2 * N - 1) mphase = 2;
          end
          2: begin m_en = 1'b0; mphase = 3; end
          default: begin m_en = 1'b0; mphase = 0; end
        endcase
      end
      e_busy  = (mphase != 0);
      e_ready = (mphase == 1) && (macc < mlen);
      e_done  = (mphase == 3);
      e_en    = m_en;
      e_lanes = model_lanes();
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      IN_DATA[i*W +: W]   = $urandom;
      IN_DATA_B[i*W +: W] = $urandom;
    end
  endtask

  task automatic run_to_done(input int max_cyc, output int en_cnt);
    bit seen;
    seen   = 1'b0;
    en_cnt = 0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      tick();
      if (EN_OUT) en_cnt++;
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: DONE not seen within %0d cycles, got none expected pulse", max_cyc);
    end
  endtask

  initial begin
    int am[N][K2];
    int bm[K2][N];
    logic [NW-1:0] ev;
    int en_cnt, en_tot, dcnt;
    longint s;

    RSTN = 1'b0; START = 1'b0; LEN = '0; IN_VALID = 1'b0;
    IN_DATA = '0; IN_DATA_B = '0;
    pe_clear();
    repeat (3) tick();
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_ready", IN_READY, 1'b0);
    chk1("rst_en", EN_OUT, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    chkv("rst_lanes", LANE_OUT, '0);
    RSTN = 1'b1;
    tick();

    // Test 1: LEN=1, vector {1,2,3,4}, IN_VALID held high
    START = 1'b1; LEN = 16'd1; IN_VALID = 1'b1;
    for (int i = 0; i < N; i++) IN_DATA[i*W +: W] = W'(i + 1);
    tick();
    START = 1'b0;
    chk1("t1_ready_c", IN_READY, 1'b1);
    for (int t = 1; t <= 10; t++) begin
      tick();
      ev = '0;
      for (int i = 0; i < N; i++) if (t == i + 1) ev[i*W +: W] = W'(i + 1);
      chkv($sformatf("t1_lanes_c+%0d", t), LANE_OUT, ev);
      chk1($sformatf("t1_en_c+%0d", t), EN_OUT, (t <= 8));
      chk1($sformatf("t1_done_c+%0d", t), DONE, (t == 9));
      chk1($sformatf("t1_busy_c+%0d", t), BUSY, (t <= 9));
    end
    IN_VALID = 1'b0;

    // Test 2: LEN=3 with a 2-cycle stall, plus 4x4 array product
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K2; k++) begin
        am[i][k] = int'($urandom_range(1, 15));
        bm[k][i] = int'($urandom_range(1, 15));
      end
    pe_clear();
    START = 1'b1; LEN = 16'd3; IN_VALID = 1'b0;
    tick();
    START = 1'b0;
    en_tot = 0;
    for (int k = 0; k < K2; k++) begin
      for (int i = 0; i < N; i++) begin
        IN_DATA[i*W +: W]   = W'(am[i][k]);
        IN_DATA_B[i*W +: W] = W'(bm[k][i]);
      end
      IN_VALID = 1'b1;
      tick();
      chk1($sformatf("t2_en_vec%0d", k), EN_OUT, 1'b1);
      en_tot++;
      if (k == 0) begin
        IN_VALID = 1'b0;
        ev = '0;
        ev[0 +: W] = W'(am[0][0]);
        for (int st = 0; st < 2; st++) begin
          tick();
          chk1($sformatf("t2_stall_en%0d", st), EN_OUT, 1'b0);
          chkv($sformatf("t2_stall_lanes%0d", st), LANE_OUT, ev);
        end
      end
    end
    IN_VALID = 1'b0;
    run_to_done(100, en_cnt);
    chki("t2_en_total", en_tot + en_cnt, 10);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K2; k++) s += longint'(am[i][k]) * longint'(bm[k][j]);
        chki($sformatf("t2_prod_%0d_%0d", i, j), acc[i][j], s);
      end
    tick();

    // Test 3: LEN=0
    START = 1'b1; LEN = '0; IN_VALID = 1'b1;
    tick();
    START = 1'b0;
    chk1("t3_done", DONE, 1'b1);
    chk1("t3_busy", BUSY, 1'b1);
    chk1("t3_en", EN_OUT, 1'b0);
    chk1("t3_ready", IN_READY, 1'b0);
    tick();
    chk1("t3_done_gone", DONE, 1'b0);
    chk1("t3_idle", BUSY, 1'b0);
    IN_VALID = 1'b0;

    // Test 4: reset during FLUSH, then a fresh LEN=2 run
    START = 1'b1; LEN = 16'd2; IN_VALID = 1'b1; rand_data();
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk1("t4_flush_ready", IN_READY, 1'b0);
    chk1("t4_flush_en", EN_OUT, 1'b1);
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    chk1("t4_busy", BUSY, 1'b0);
    chk1("t4_en", EN_OUT, 1'b0);
    chk1("t4_done", DONE, 1'b0);
    chkv("t4_lanes", LANE_OUT, '0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DONE) dcnt++;
    end
    chki("t4_no_done", dcnt, 0);
    START = 1'b1; LEN = 16'd2; IN_VALID = 1'b1;
    tick();
    START = 1'b0;
    run_to_done(100, en_cnt);
    chki("t4_fresh_en", en_cnt, 9);
    tick();

    // Test 5: START ignored in FEED and DONE, back-to-back runs
    START = 1'b1; LEN = 16'd3; IN_VALID = 1'b1;
    tick();
    START = 1'b0;
    tick();
    START = 1'b1; LEN = 16'd7;
    tick();
    START = 1'b0;
    run_to_done(100, en_cnt);
    chki("t5_no_recapture", 2 + en_cnt, 10);
    START = 1'b1; LEN = 16'd5;
    tick();
    chk1("t5_done_start_ignored", BUSY, 1'b0);
    LEN = 16'd1;
    tick();
    START = 1'b0;
    chk1("t5_b2b_busy", BUSY, 1'b1);
    chk1("t5_b2b_ready", IN_READY, 1'b1);
    run_to_done(100, en_cnt);
    chki("t5_b2b_en", en_cnt, 8);
    IN_VALID = 1'b0;
    tick();

    // Longer run with random stalls
    START = 1'b1; LEN = 16'd300;
    tick();
    START = 1'b0;
    en_tot = 0;
    dcnt = 0;
    for (int k = 0; k < 2000 && dcnt == 0; k++) begin
      IN_VALID = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
      if (EN_OUT) en_tot++;
      if (DONE) dcnt++;
    end
    chki("long_en_total", en_tot, 300 + 2 * N - 1);
    chki("long_done_seen", dcnt, 1);

    // Fully random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 3000; k++) begin
      RSTN     = ($urandom_range(0, 299) != 0);
      START    = ($urandom_range(0, 7) == 0);
      LEN      = LW'($urandom_range(0, 6));
      IN_VALID = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
    end
    RSTN = 1'b1; START = 1'b0; IN_VALID = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
